// File: rtl/snake_pkg.sv
// snake_pkg: dialog state enum, vga timing struct, colour width and default dialog geometry/colours
package snake_pkg;
  localparam int RGB_B = 12;
  localparam int DLG_N_BUTTONS = 2;
  localparam int DLG_X = 0, DLG_Y = 0, DLG_W = 400, DLG_H = 300;
  localparam int DLG_BTN_X = 50, DLG_BTN_Y = 100, DLG_BTN_W = 300, DLG_BTN_H = 40;
  localparam int DLG_BTN_GAP = 20, DLG_BORDER_W = 3;
  localparam logic [RGB_B-1:0] DLG_BG_COLOR = 12'hF00, DLG_BTN_COLOR = 12'h0F0, DLG_HL_COLOR = 12'hFF0;
  localparam int DLG_BLINK_FRAMES = 30, DLG_CONFIRM_FRAMES = 15, DLG_WRAP = 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, CONFIRM, DONE} dialog_state_t;
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_t;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: vga timing bundle (hcount, vcount, syncs, blanks) with in/out modports
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  modport in (input hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_dialog_ctrl.sv
// dialog_ctrl: key edges + selection FSM + blink/confirm counters; in: show, keys, frame_tick; out: sel_idx, sel_valid, active, blink_on, flash_on
module dialog_ctrl import snake_pkg::*; #(
  parameter int N_BUTTONS = DLG_N_BUTTONS,
  parameter int BLINK_FRAMES = DLG_BLINK_FRAMES,
  parameter int CONFIRM_FRAMES = DLG_CONFIRM_FRAMES,
  parameter int WRAP = DLG_WRAP,
  localparam int SEL_W = sel_w(N_BUTTONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             show,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_enter,
  input  logic             frame_tick,
  output logic [SEL_W-1:0] sel_idx,
  output logic             sel_valid,
  output logic             active,
  output logic             blink_on,
  output logic             flash_on
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_BUTTONS - 1);
  localparam logic [15:0] BLINK_MAX = 16'(BLINK_FRAMES - 1);
  localparam logic [15:0] CONF_MAX = 16'(CONFIRM_FRAMES - 1);
  dialog_state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, sel_up, sel_dn;
  logic [15:0] blink_cnt_q, blink_cnt_d, conf_cnt_q, conf_cnt_d;
  logic blink_q, blink_d, flash_q, flash_d;
  logic [2:0] keys_q, keys_d;
  logic up_e, dn_e, en_e;
  always_comb begin
    keys_d = {key_up, key_down, key_enter};
    {up_e, dn_e, en_e} = keys_d & ~keys_q;
    sel_up = sel_q == '0 ? (WRAP != 0 ? LAST : '0) : sel_q - 1'b1;
    sel_dn = sel_q == LAST ? (WRAP != 0 ? '0 : LAST) : sel_q + 1'b1;
    state_d = state_q;
    sel_d = sel_q;
    blink_cnt_d = blink_cnt_q;
    blink_d = blink_q;
    conf_cnt_d = conf_cnt_q;
    flash_d = flash_q;
    case (state_q)
      IDLE: if (show) begin
        state_d = ACTIVE;
        sel_d = '0;
        blink_cnt_d = '0;
        blink_d = 1'b1;
      end
      ACTIVE: if (en_e) begin
        state_d = CONFIRM;
        conf_cnt_d = '0;
        flash_d = 1'b0;
      end else if (up_e ^ dn_e) begin
        sel_d = up_e ? sel_up : sel_dn;
        blink_cnt_d = '0;
        blink_d = 1'b1;
      end else if (frame_tick) begin
        blink_cnt_d = blink_cnt_q == BLINK_MAX ? '0 : blink_cnt_q + 16'd1;
        blink_d = blink_cnt_q == BLINK_MAX ? ~blink_q : blink_q;
      end
      CONFIRM: if (frame_tick) begin
        conf_cnt_d = conf_cnt_q + 16'd1;
        flash_d = ~flash_q;
        state_d = conf_cnt_q == CONF_MAX ? DONE : CONFIRM;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      blink_cnt_q <= '0;
      blink_q <= 1'b0;
      conf_cnt_q <= '0;
      flash_q <= 1'b0;
      keys_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q <= blink_d;
      conf_cnt_q <= conf_cnt_d;
      flash_q <= flash_d;
      keys_q <= keys_d;
    end
  end
  assign sel_idx = sel_q;
  assign sel_valid = state_q == DONE;
  assign active = state_q == ACTIVE || state_q == CONFIRM;
  assign blink_on = blink_q || state_q == CONFIRM;
  assign flash_on = flash_q && state_q == CONFIRM;
endmodule

// File: rtl/draw_dialog.sv
// draw_dialog: modal dialog overlay stage; dialog_ctrl + 2-cycle pixel pipeline (region compare, colour mux); ports: keys/show in, vga_if + rgb through, sel_idx/sel_valid/active out
module draw_dialog import snake_pkg::*; #(
  parameter int N_BUTTONS = DLG_N_BUTTONS,
  parameter int X = DLG_X,
  parameter int Y = DLG_Y,
  parameter int W = DLG_W,
  parameter int H = DLG_H,
  parameter int BTN_X = DLG_BTN_X,
  parameter int BTN_Y = DLG_BTN_Y,
  parameter int BTN_W = DLG_BTN_W,
  parameter int BTN_H = DLG_BTN_H,
  parameter int BTN_GAP = DLG_BTN_GAP,
  parameter int BORDER_W = DLG_BORDER_W,
  parameter logic [RGB_B-1:0] BG_COLOR = DLG_BG_COLOR,
  parameter logic [RGB_B-1:0] BTN_COLOR = DLG_BTN_COLOR,
  parameter logic [RGB_B-1:0] HL_COLOR = DLG_HL_COLOR,
  parameter int BLINK_FRAMES = DLG_BLINK_FRAMES,
  parameter int CONFIRM_FRAMES = DLG_CONFIRM_FRAMES,
  parameter int WRAP = DLG_WRAP,
  localparam int SEL_W = sel_w(N_BUTTONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             show,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_enter,
  vga_if.in                vga_in,
  input  logic [RGB_B-1:0] rgb_i,
  vga_if.out               vga_out,
  output logic [RGB_B-1:0] rgb_o,
  output logic [SEL_W-1:0] sel_idx,
  output logic             sel_valid,
  output logic             active
);
  localparam int NB = 1 << SEL_W;
  localparam logic [10:0] X0 = 11'(X), X1 = 11'(X + W), Y0 = 11'(Y), Y1 = 11'(Y + H);
  localparam logic [10:0] BX0 = 11'(X + BTN_X), BX1 = 11'(X + BTN_X + BTN_W), BW = 11'(BORDER_W);
  typedef struct packed {
    vga_t vga;
    logic [RGB_B-1:0] rgb;
    logic box;
    logic btn;
    logic sel_bdr;
    logic sel_in;
  } s1_t;
  s1_t s1_q, s1_d;
  vga_t vga_q, vga_d;
  logic [RGB_B-1:0] rgb_q, rgb_d;
  logic [10:0] h, v;
  logic [NB-1:0] in_btn, on_bdr;
  logic frame_tick, blink_on, flash_on;
  assign h = vga_in.hcount;
  assign v = vga_in.vcount;
  assign frame_tick = h == '0 && v == '0;
  dialog_ctrl #(
    .N_BUTTONS(N_BUTTONS), .BLINK_FRAMES(BLINK_FRAMES), .CONFIRM_FRAMES(CONFIRM_FRAMES), .WRAP(WRAP)
  ) u_ctrl (
    .clk(clk), .rst(rst), .show(show), .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
    .frame_tick(frame_tick), .sel_idx(sel_idx), .sel_valid(sel_valid), .active(active),
    .blink_on(blink_on), .flash_on(flash_on)
  );
  // padded to a power of two so sel_idx can index without going out of range
  for (genvar k = 0; k < NB; k++) begin : g_btn
    localparam logic [10:0] BY0 = 11'(Y + BTN_Y + k * (BTN_H + BTN_GAP));
    localparam logic [10:0] BY1 = 11'(Y + BTN_Y + k * (BTN_H + BTN_GAP) + BTN_H);
    assign in_btn[k] = k < N_BUTTONS && h >= BX0 && h < BX1 && v >= BY0 && v < BY1;
    assign on_bdr[k] = in_btn[k] && (h < BX0 + BW || h >= BX1 - BW || v < BY0 + BW || v >= BY1 - BW);
  end
  always_comb begin
    s1_d = {h, v, vga_in.hsync, vga_in.vsync, vga_in.hblnk, vga_in.vblnk, rgb_i,
            h >= X0 && h < X1 && v >= Y0 && v < Y1, |in_btn, on_bdr[sel_idx], in_btn[sel_idx]};
    vga_d = s1_q.vga;
    rgb_d = !active || s1_q.vga.hblnk || s1_q.vga.vblnk ? s1_q.rgb :
            s1_q.sel_bdr && blink_on ? HL_COLOR :
            s1_q.sel_in && flash_on ? HL_COLOR :
            s1_q.btn ? BTN_COLOR :
            s1_q.box ? BG_COLOR : s1_q.rgb;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      vga_q <= '0;
      rgb_q <= '0;
    end else begin
      s1_q <= s1_d;
      vga_q <= vga_d;
      rgb_q <= rgb_d;
    end
  end
  assign vga_out.hcount = vga_q.hcount;
  assign vga_out.vcount = vga_q.vcount;
  assign vga_out.hsync = vga_q.hsync;
  assign vga_out.vsync = vga_q.vsync;
  assign vga_out.hblnk = vga_q.hblnk;
  assign vga_out.vblnk = vga_q.vblnk;
  assign rgb_o = rgb_q;
endmodule

// File: tb/tb_draw_dialog.sv
// tb_draw_dialog: directed checks of draw_dialog drawing, navigation, confirm flow and reset
module tb_draw_dialog;
  logic clk = 1'b0, rst = 1'b1, show = 1'b0, key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0;
  logic [11:0] rgb_i = 12'h000, rgb_o0, rgb_o1;
  logic [1:0] sel0, sel1;
  logic sv0, sv1, act0, act1;
  int n_chk = 0, n_fail = 0;
  vga_if vi();
  vga_if vo0();
  vga_if vo1();
  draw_dialog #(.N_BUTTONS(3), .WRAP(1)) u0 (
    .clk(clk), .rst(rst), .show(show), .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
    .vga_in(vi), .rgb_i(rgb_i), .vga_out(vo0), .rgb_o(rgb_o0), .sel_idx(sel0), .sel_valid(sv0), .active(act0)
  );
  draw_dialog #(.N_BUTTONS(3), .WRAP(0)) u1 (
    .clk(clk), .rst(rst), .show(show), .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
    .vga_in(vi), .rgb_i(rgb_i), .vga_out(vo1), .rgb_o(rgb_o1), .sel_idx(sel1), .sel_valid(sv1), .active(act1)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic b, input logic [11:0] c);
    vi.hcount = h;
    vi.vcount = v;
    vi.hsync = 1'b0;
    vi.vsync = 1'b0;
    vi.hblnk = b;
    vi.vblnk = 1'b0;
    rgb_i = c;
  endtask
  task automatic park;
    drive(11'd500, 11'd500, 1'b0, 12'h000);
  endtask
  task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic b, input logic [11:0] c);
    drive(h, v, b, c);
    step;
    step;
    park;
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      drive(11'd0, 11'd0, 1'b0, 12'h000);
      step;
      park;
    end
  endtask
  task automatic press(input logic u, input logic d, input logic e);
    key_up = u;
    key_down = d;
    key_enter = e;
    step;
    key_up = 1'b0;
    key_down = 1'b0;
    key_enter = 1'b0;
    step;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    park;
    repeat (3) step;
    n_chk++; if (rgb_o0 !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", rgb_o0); end
    n_chk++; if ({vo0.hcount, vo0.vcount, vo0.hblnk} !== 23'd0) begin n_fail++; $display("FAIL reset_vga: got %0d/%0d want 0/0", vo0.hcount, vo0.vcount); end
    n_chk++; if ({act0, sv0, sel0} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got act=%b sv=%b sel=%0d want 0/0/0", act0, sv0, sel0); end
    rst = 1'b0;
    step;
  endtask
  task automatic test_passthrough;
    logic [10:0] ph[6] = '{11'd10, 11'd1, 11'd0, 11'd399, 11'd700, 11'd500};
    logic [10:0] pv[6] = '{11'd10, 11'd1, 11'd0, 11'd299, 11'd20, 11'd500};
    logic pb[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [11:0] pc[6] = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h321};
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(ph[i], pv[i], pb[i], pc[i]); else park;
      step;
      if (i >= 1) begin
        n_chk++; if (rgb_o0 !== pc[i-1]) begin n_fail++; $display("FAIL idle_rgb[%0d]: got %h want %h", i - 1, rgb_o0, pc[i-1]); end
        n_chk++; if ({vo0.hcount, vo0.vcount, vo0.hblnk} !== {ph[i-1], pv[i-1], pb[i-1]}) begin n_fail++; $display("FAIL idle_vga[%0d]: got %0d/%0d/%b want %0d/%0d/%b", i - 1, vo0.hcount, vo0.vcount, vo0.hblnk, ph[i-1], pv[i-1], pb[i-1]); end
      end
      n_chk++; if ({act0, sv0} !== 2'b00) begin n_fail++; $display("FAIL idle_ctrl[%0d]: got act=%b sv=%b want 0/0", i, act0, sv0); end
    end
  endtask
  task automatic test_draw;
    show = 1'b1;
    step;
    show = 1'b0;
    n_chk++; if ({act0, sel0} !== 3'b100) begin n_fail++; $display("FAIL show_open: got act=%b sel=%0d want 1/0", act0, sel0); end
    pix(11'd1, 11'd1, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'hF00) begin n_fail++; $display("FAIL box_fill: got %h want F00", rgb_o0); end
    pix(11'd200, 11'd180, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'h0F0) begin n_fail++; $display("FAIL btn1_fill: got %h want 0F0", rgb_o0); end
    pix(11'd50, 11'd100, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'hFF0) begin n_fail++; $display("FAIL btn0_border: got %h want FF0", rgb_o0); end
    pix(11'd52, 11'd102, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'hFF0) begin n_fail++; $display("FAIL btn0_border_inner: got %h want FF0", rgb_o0); end
    pix(11'd53, 11'd103, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'h0F0) begin n_fail++; $display("FAIL btn0_past_border: got %h want 0F0", rgb_o0); end
    pix(11'd350, 11'd120, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'hF00) begin n_fail++; $display("FAIL btn0_right_open: got %h want F00", rgb_o0); end
    pix(11'd200, 11'd140, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'hF00) begin n_fail++; $display("FAIL btn_gap: got %h want F00", rgb_o0); end
    pix(11'd1, 11'd1, 1'b1, 12'h555);
    n_chk++; if (rgb_o0 !== 12'h555) begin n_fail++; $display("FAIL blank_pass: got %h want 555", rgb_o0); end
    pix(11'd500, 11'd500, 1'b0, 12'h777);
    n_chk++; if (rgb_o0 !== 12'h777) begin n_fail++; $display("FAIL outside_pass: got %h want 777", rgb_o0); end
  endtask
  task automatic test_nav;
    logic [1:0] e0[6] = '{2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};
    logic [1:0] e1[6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 6; i++) begin
      press(i >= 3, i < 3, 1'b0);
      n_chk++; if (sel0 !== e0[i]) begin n_fail++; $display("FAIL nav_wrap[%0d]: got %0d want %0d", i, sel0, e0[i]); end
      n_chk++; if (sel1 !== e1[i]) begin n_fail++; $display("FAIL nav_sat[%0d]: got %0d want %0d", i, sel1, e1[i]); end
    end
  endtask
  task automatic test_keys;
    press(1'b1, 1'b1, 1'b0);
    n_chk++; if ({sel0, sel1} !== 4'b0000) begin n_fail++; $display("FAIL up_down_together: got %0d/%0d want 0/0", sel0, sel1); end
    key_down = 1'b1;
    repeat (100) step;
    key_down = 1'b0;
    step;
    n_chk++; if ({sel0, sel1} !== 4'b0101) begin n_fail++; $display("FAIL held_key_one_step: got %0d/%0d want 1/1", sel0, sel1); end
  endtask
  task automatic test_blink;
    tick(29);
    pix(11'd50, 11'd160, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'hFF0) begin n_fail++; $display("FAIL blink_still_on: got %h want FF0", rgb_o0); end
    pix(11'd50, 11'd100, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'h0F0) begin n_fail++; $display("FAIL unselected_border: got %h want 0F0", rgb_o0); end
    tick(1);
    pix(11'd50, 11'd160, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'h0F0) begin n_fail++; $display("FAIL blink_off: got %h want 0F0", rgb_o0); end
  endtask
  task automatic test_confirm;
    int pulses = 0;
    press(1'b0, 1'b0, 1'b1);
    n_chk++; if (act0 !== 1'b1) begin n_fail++; $display("FAIL confirm_active: got %b want 1", act0); end
    pix(11'd50, 11'd160, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'hFF0) begin n_fail++; $display("FAIL confirm_border_forced: got %h want FF0", rgb_o0); end
    pix(11'd200, 11'd180, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'h0F0) begin n_fail++; $display("FAIL flash_phase0: got %h want 0F0", rgb_o0); end
    tick(1);
    pix(11'd200, 11'd180, 1'b0, 12'h555);
    n_chk++; if (rgb_o0 !== 12'hFF0) begin n_fail++; $display("FAIL flash_phase1: got %h want FF0", rgb_o0); end
    tick(13);
    n_chk++; if ({sv0, act0} !== 2'b01) begin n_fail++; $display("FAIL confirm_14_ticks: got sv=%b act=%b want 0/1", sv0, act0); end
    tick(1);
    n_chk++; if ({sv0, sel0, act0} !== 4'b1010) begin n_fail++; $display("FAIL sel_valid_pulse: got sv=%b sel=%0d act=%b want 1/1/0", sv0, sel0, act0); end
    step;
    n_chk++; if (sv0 !== 1'b0) begin n_fail++; $display("FAIL sel_valid_one_cycle: got %b want 0", sv0); end
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) tick(1); else step;
      pulses += int'(sv0);
    end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL no_extra_pulse: got %0d want 0", pulses); end
    n_chk++; if (sel0 !== 2'd1) begin n_fail++; $display("FAIL sel_holds: got %0d want 1", sel0); end
    pix(11'd200, 11'd180, 1'b0, 12'h246);
    n_chk++; if (rgb_o0 !== 12'h246) begin n_fail++; $display("FAIL done_passthrough: got %h want 246", rgb_o0); end
  endtask
  task automatic test_rst_confirm;
    int pulses = 0, acts = 0;
    show = 1'b1;
    step;
    show = 1'b0;
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    tick(3);
    n_chk++; if ({act0, sel0} !== 3'b101) begin n_fail++; $display("FAIL pre_reset_confirm: got act=%b sel=%0d want 1/1", act0, sel0); end
    rst = 1'b1;
    step;
    n_chk++; if ({act0, sv0, sel0} !== 4'b0000) begin n_fail++; $display("FAIL reset_mid_confirm: got act=%b sv=%b sel=%0d want 0/0/0", act0, sv0, sel0); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) tick(1); else step;
      pulses += int'(sv0);
      acts += int'(act0);
    end
    n_chk++; if ({pulses, acts} !== 64'd0) begin n_fail++; $display("FAIL after_reset_quiet: got sv=%0d act=%0d want 0/0", pulses, acts); end
  endtask
  initial begin
    park;
    test_reset;
    test_passthrough;
    test_draw;
    test_nav;
    test_keys;
    test_blink;
    test_confirm;
    test_rst_confirm;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
